// File: rtl/stim_pattern_gen.sv
// Stimulus source: emits a burst of `length` N-bit words (count, LFSR, walking-one
// or alternating pattern) over a valid/ready stream, with backpressure and abort.
module stim_pattern_gen #(
    parameter int            N     = 8,
    parameter int            LEN_W = 8,
    parameter logic [N-1:0]  SEED  = 'h01,
    parameter logic [N-1:0]  TAPS  = 'hB8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] length,
    input  logic             abort,
    input  logic             ready,
    output logic [N-1:0]     data_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {M_COUNT, M_LFSR, M_WALK, M_ALT} mode_e;

    // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
    localparam logic [N-1:0] SEED_EFF = (SEED == '0) ? N'(1) : SEED;

    function automatic logic [N-1:0] alt_init();
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) begin
            w[i] = (i % 2 == 0);
        end
        return w;
    endfunction

    localparam logic [N-1:0] ALT0 = alt_init();

    function automatic logic [N-1:0] first_word(input mode_e m);
        case (m)
            M_COUNT: return '0;
            M_LFSR:  return SEED_EFF;
            M_WALK:  return N'(1);
            default: return ALT0;
        endcase
    endfunction

    function automatic logic [N-1:0] next_word(input mode_e m, input logic [N-1:0] w);
        case (m)
            M_COUNT: return w + N'(1);
            M_LFSR:  return (w >> 1) ^ (w[0] ? TAPS : '0);
            M_WALK:  return {w[N-2:0], w[N-1]};
            default: return ~w;
        endcase
    endfunction

    state_e           state;
    mode_e            mode_q;
    logic [LEN_W-1:0] count;

    // NOTE: every register here, including the latched mode and count, is cleared
    // by the synchronous reset, and all state updates use non-blocking assignments
    // so that each register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            mode_q   <= M_COUNT;
            count    <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (length != '0) begin
                            mode_q   <= mode_e'(mode);
                            count    <= length;
                            data_out <= first_word(mode_e'(mode));
                            valid    <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    // Abort wins over an accept on the same cycle; the beat is dropped.
                    if (abort) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (ready) begin
                        count <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            data_out <= next_word(mode_q, data_out);
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Directed bench for stim_pattern_gen: expected beats are queued when a burst is
// started and compared as the sink accepts them.
module tb_stim_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [7:0] length;
    logic       abort;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int done_cnt = 0;
    int busy_cycles;
    logic [7:0] sb[$];
    logic [7:0] exp_w;
    logic [7:0] prev_data = '0;
    logic       prev_stall = 1'b0;
    logic       prev_done = 1'b0;

    stim_pattern_gen #(.N(8), .LEN_W(8), .SEED(8'h01), .TAPS(8'hB8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .length(length),
        .abort(abort), .ready(ready), .data_out(data_out), .valid(valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sample on the falling edge, between input updates and DUT edges.
    always @(negedge clk) begin
        if (reset && valid && ready && !abort) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("beat", data_out, exp_w);
            end
            accepts++;
        end
        if (prev_stall) check("hold", {valid, data_out}, {1'b1, prev_data});
        prev_stall = reset && valid && !ready && !abort;
        prev_data  = data_out;
        if (done) begin
            done_cnt++;
            check("done_one_cycle", prev_done, 0);
        end
        prev_done = done;
    end

    task automatic start_burst(input logic [1:0] m, input logic [7:0] len);
        accepts = 0;
        mode    = m;
        length  = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit toggle);
        int n = 0;
        busy_cycles = 0;
        while (!done && n < 300) begin
            if (busy) busy_cycles++;
            if (toggle) ready = ~ready;
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        tick();
        check({tag, "_done_low"}, done, 0);
        check({tag, "_idle"}, {valid, busy}, 2'b00);
        ready = 1'b1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 2'd0; length = 8'd0; abort = 1'b0; ready = 1'b1;
        tick(); tick();
        check("rst_outputs", {data_out, valid, busy, done}, 11'd0);
        reset = 1'b1;
        tick();

        // T1: count, len 5, ready always high
        sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h02);
        sb.push_back(8'h03); sb.push_back(8'h04);
        start_burst(2'd0, 8'd5);
        check("t1_latency_valid", {valid, busy, data_out}, {2'b11, 8'h00});
        wait_done("t1", 1'b0);
        check("t1_busy_cycles", busy_cycles, 5);
        check("t1_accepts", accepts, 5);

        // T2: LFSR, len 4
        sb.push_back(8'h01); sb.push_back(8'hB8); sb.push_back(8'h5C); sb.push_back(8'h2E);
        start_burst(2'd1, 8'd4);
        wait_done("t2", 1'b0);
        check("t2_accepts", accepts, 4);

        // T3: walking one, len 10 with wrap, ready toggling
        for (int i = 0; i < 10; i++) sb.push_back(8'h01 << (i % 8));
        start_burst(2'd2, 8'd10);
        wait_done("t3", 1'b1);
        check("t3_accepts", accepts, 10);

        // T4: alternate, len 3, first beat stalled 3 cycles, start pulsed mid-burst
        sb.push_back(8'h55); sb.push_back(8'hAA); sb.push_back(8'h55);
        ready = 1'b0;
        start_burst(2'd3, 8'd3);
        tick();
        mode = 2'd0; length = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t4_stalled", {valid, data_out}, {1'b1, 8'h55});
        ready = 1'b1;
        wait_done("t4", 1'b0);
        check("t4_accepts", accepts, 3);

        // T5: count, len 20, abort while beat 6 is on the bus
        for (int i = 0; i < 5; i++) sb.push_back(8'(i));
        start_burst(2'd0, 8'd20);
        repeat (5) tick();
        check("t5_beat6", {valid, data_out}, {1'b1, 8'h05});
        done_cnt = 0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_idle", {valid, busy, done}, 3'b000);
        repeat (3) tick();
        check("t5_no_done", done_cnt, 0);
        check("t5_accepts", accepts, 5);
        check("t5_sb_empty", sb.size(), 0);
        sb.push_back(8'h00); sb.push_back(8'h01);
        start_burst(2'd0, 8'd2);
        wait_done("t5b", 1'b0);

        // T6a: zero-length burst
        start_burst(2'd0, 8'd0);
        check("t6_len0_done", {done, valid, busy}, 3'b100);
        tick();
        check("t6_len0_after", {done, valid}, 2'b00);

        // T6b: reset in the middle of a burst, then restart from w0
        sb.push_back(8'h01); sb.push_back(8'h02);
        start_burst(2'd2, 8'd8);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("t6_reset_outputs", {data_out, valid, busy, done}, 11'd0);
        check("t6_reset_accepts", accepts, 2);
        reset = 1'b1;
        tick();
        sb.push_back(8'h01); sb.push_back(8'h02);
        start_burst(2'd2, 8'd2);
        wait_done("t6b", 1'b0);
        check("t6b_accepts", accepts, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
